// File: rtl/uart_mem_loader_pkg.sv
// Shared definitions for the UART image loader: FSM state encoding and the
// receiver oversample constant used by both UART blocks.
package uart_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACK  = 2'b10,
        DONE = 2'b11
    } ldr_state_t;

    localparam int unsigned UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_mem_loader.sv
// Writes bytes from the UART receiver sequentially into the image RAM.
// Optional checksum accumulator enabled by defining LOADER_CHECKSUM_EN.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NUM_BYTES = 65536
) (
    input  logic              clk_,
    input  logic              rst_n,
    input  logic              start,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              rx_rdy_clr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [7:0]        checksum
);

    localparam logic [ADDR_W:0] NUM_B = (ADDR_W+1)'(NUM_BYTES);

    ldr_state_t        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic              drop_q, drop_d;
    logic              we_d, clr_d, busy_d, done_d, ovr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d;
    logic              arm, capture;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // an already-acknowledged byte stays pending until rx_rdy drops
        drop_d  = drop_q & rx_rdy;
        we_d    = 1'b0;
        clr_d   = 1'b0;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        busy_d  = busy;
        done_d  = done;
        ovr_d   = overrun;
        arm     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    arm     = 1'b1;
                    state_d = LOAD;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    ovr_d   = 1'b0;
                    busy_d  = 1'b1;
                end else if (rx_rdy && !drop_q) begin
                    clr_d  = 1'b1;
                    ovr_d  = 1'b1;
                    drop_d = 1'b1;
                end
            end
            LOAD: begin
                if (rx_rdy && !drop_q) begin
                    capture = 1'b1;
                    we_d    = 1'b1;
                    clr_d   = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = rx_data;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!rx_rdy) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == NUM_B) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            mem_we     <= 1'b0;
            rx_rdy_clr <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            mem_we     <= we_d;
            rx_rdy_clr <= clr_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            busy       <= busy_d;
            done       <= done_d;
            overrun    <= ovr_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // summed at capture so the total is final by the time done rises
    always_ff @(posedge clk_ or negedge rst_n) begin
        if (!rst_n)       checksum <= '0;
        else if (arm)     checksum <= '0;
        else if (capture) checksum <= checksum + rx_data;
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader (ADDR_W=2, NUM_BYTES=4) with a
// behavioural UART receiver model and randomized byte loads.
module tb_uart_mem_loader;

    localparam int AW = 2;
    localparam int NB = 4;

    logic          clk_ = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_rdy_clr, mem_we, busy, done, overrun;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, checksum;

    uart_mem_loader #(.ADDR_W(AW), .NUM_BYTES(NB)) dut (
        .clk_(clk_), .rst_n(rst_n), .start(start), .rx_rdy(rx_rdy),
        .rx_data(rx_data), .rx_rdy_clr(rx_rdy_clr), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .overrun(overrun), .checksum(checksum)
    );

    always #5 clk_ = ~clk_;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_addr_q[$];
    int exp_data_q[$];
    int we_cnt  = 0;
    int clr_cnt = 0;
    bit prev_we  = 0;
    bit prev_clr = 0;

    // reference model state: next address and running byte sum of this load
    int addr_model = 0;
    int sum_model  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: pops the expected write on every mem_we, checks pulse widths
    always @(negedge clk_) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                chk("we_width", int'(prev_we), 0);
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    chk("wr_addr", int'(mem_addr), exp_addr_q.pop_front());
                    chk("wr_data", int'(mem_wdata), exp_data_q.pop_front());
                end
            end
            if (rx_rdy_clr) begin
                clr_cnt++;
                chk("clr_width", int'(prev_clr), 0);
            end
            prev_we  = mem_we;
            prev_clr = rx_rdy_clr;
        end else begin
            prev_we  = 0;
            prev_clr = 0;
        end
    end

    task automatic pulse_start(input bit new_load);
        @(negedge clk_);
        start = 1'b1;
        @(negedge clk_);
        start = 1'b0;
        if (new_load) begin
            addr_model = 0;
            sum_model  = 0;
        end
    endtask

    // receiver model: rdy rises, is cleared on the edge after rdy_clr is seen
    task automatic send_byte(input logic [7:0] b, input int hold, input bit expect_write);
        int  c0 = clr_cnt;
        int  w0 = we_cnt;
        bit  seen = 0;
        if (expect_write) begin
            exp_addr_q.push_back(addr_model % (1 << AW));
            exp_data_q.push_back(int'(b));
            addr_model++;
            sum_model = (sum_model + int'(b)) % 256;
        end
        @(posedge clk_); #1;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk_); #1;
            if (rx_rdy_clr) seen = 1;
        end
        if (!seen) chk("clr_timeout", 0, 1);
        @(posedge clk_); #1;
        for (int i = 0; i < hold; i++) begin
            if (expect_write) chk("done_before_drop", int'(done), 0);
            @(posedge clk_); #1;
        end
        rx_rdy = 1'b0;
        repeat (4) @(posedge clk_);
        #1;
        chk("clr_per_byte", clr_cnt - c0, 1);
        chk("we_per_byte", we_cnt - w0, int'(expect_write));
    endtask

    function automatic int exp_sum();
`ifdef LOADER_CHECKSUM_EN
        return sum_model;
`else
        return 0;
`endif
    endfunction

    task automatic check_done();
        chk("done", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("checksum", int'(checksum), exp_sum());
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_clr"}, int'(rx_rdy_clr), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_checksum"}, int'(checksum), 0);
    endtask

    initial begin
        logic [7:0] fixed [4];
        fixed[0] = 8'hA5; fixed[1] = 8'h3C; fixed[2] = 8'hFF; fixed[3] = 8'h01;

        repeat (3) @(posedge clk_);
        #1 check_all_zero("reset");
        @(negedge clk_);
        rst_n = 1'b1;

        // stray byte before any start
        send_byte(8'h55, 0, 0);
        chk("overrun_idle", int'(overrun), 1);
        chk("busy_idle", int'(busy), 0);
        pulse_start(1);
        #1;
        chk("overrun_cleared", int'(overrun), 0);
        chk("busy_after_start", int'(busy), 1);
        chk("done_after_start", int'(done), 0);

        // fixed load; last byte held high to show the count waits for rdy to drop
        for (int i = 0; i < 4; i++) send_byte(fixed[i], (i == 3) ? 10 : 0, 1);
        check_done();
        `ifdef LOADER_CHECKSUM_EN
        chk("checksum_e1", int'(checksum), 8'hE1);
        `endif

        // fifth byte after done is discarded
        send_byte(8'h77, 0, 0);
        chk("overrun_done", int'(overrun), 1);
        chk("done_held", int'(done), 1);

        // asynchronous reset mid-load
        pulse_start(1);
        send_byte(8'(($urandom)), 0, 1);
        send_byte(8'(($urandom)), 0, 1);
        @(posedge clk_); #3;
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        chk("queue_after_reset", exp_addr_q.size(), 0);
        @(negedge clk_);
        rst_n = 1'b1;

        // reload from address 0 with a start pulse ignored mid-load
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                pulse_start(0);
                chk("busy_midstart", int'(busy), 1);
            end
            send_byte(8'($urandom), 0, 1);
        end
        check_done();

        // randomized loads with random hold times
        for (int n = 0; n < 4; n++) begin
            pulse_start(1);
            for (int i = 0; i < 4; i++) send_byte(8'($urandom), int'($urandom_range(0, 3)), 1);
            check_done();
            chk("overrun_clean", int'(overrun), 0);
        end

        chk("queue_drained", exp_addr_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
